aes_word_loader: RTL and testbench

Word-serial front/back end for the 128-bit AES encryption core. It collects a 128-bit key and 128-bit plaintext as 32-bit words over a valid/ready stream and presents them to the core. It pulses the core's start, waits for the core's done, and captures the cipher. The cipher is returned as four 32-bit words on a second valid/ready stream. It sits directly in front of and behind the encryption core.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_word_pack.sv | 35 +++
 rtl/aes_word_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_aes_word_loader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES word-serial loader: block/word geometry,
// stream kind encodings, loader FSM states and a word-select helper.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_WORDS   = AES_BLOCK_W / AES_WORD_W;

    // in_kind encodings on the input stream
    localparam logic KIND_DATA = 1'b0;
    localparam logic KIND_KEY  = 1'b1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        DRAIN   = 2'd3
    } loader_state_t;

    // Big-endian word select: index 0 is the most significant word [127:96].
    function automatic logic [AES_WORD_W-1:0] block_word(
        input logic [AES_BLOCK_W-1:0] blk,
        input logic [1:0]             idx
    );
        logic [AES_WORD_W-1:0] w;
        unique case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_word_pack.sv
// Four-slot word register bank that assembles a 128-bit block from 32-bit
// words. Slot 0 lands in the most significant word (FIPS-197 byte order).
module aes_word_pack
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [1:0]             wr_idx,
    input  logic [AES_WORD_W-1:0]  wr_word,
    output logic [AES_BLOCK_W-1:0] block
);

    genvar gi;
    generate
        for (gi = 0; gi < AES_WORDS; gi++) begin : g_slot
            logic [AES_WORD_W-1:0] slot_reg;

            // Each slot loads only when addressed; clear wipes the whole bank.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot_reg <= '0;
                end else if (clr) begin
                    slot_reg <= '0;
                end else if (wr_en && (wr_idx == 2'(gi))) begin
                    slot_reg <= wr_word;
                end
            end

            assign block[AES_BLOCK_W-1-gi*AES_WORD_W -: AES_WORD_W] = slot_reg;
        end
    endgenerate

endmodule

// File: rtl/aes_word_loader.sv
// Word-serial front/back end for a 128-bit AES encryption core: gathers key
// and plaintext words, launches the core, waits for an edge-qualified done,
// and streams the cipher back out as four big-endian words.
module aes_word_loader
    import aes_pkg::*;
#(
    parameter int TIMEOUT = 63
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_WORD_W-1:0]  in_word,
    input  logic                   in_kind,
    output logic [AES_BLOCK_W-1:0] core_data,
    output logic [AES_BLOCK_W-1:0] core_key,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [AES_BLOCK_W-1:0] core_cipher,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_WORD_W-1:0]  out_word,
    output logic                   out_last,
    output logic                   err
);

    // WAIT lasts at most TIMEOUT cycles: timer values 0 .. TIMEOUT-1.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    loader_state_t           state_reg;
    logic                    core_start_reg;
    logic                    out_valid_reg;
    logic [1:0]              kcnt_reg;
    logic [1:0]              dcnt_reg;
    logic                    key_ok_reg;
    logic                    data_full_reg;
    logic [7:0]              timer_reg;
    logic                    done_low_reg;
    logic [AES_BLOCK_W-1:0]  result_reg;
    logic [1:0]              ocnt_reg;
    logic                    err_reg;

    logic in_collect;
    logic in_start;
    logic in_wait;
    logic in_drain;
    logic in_accept;
    logic key_wr;
    logic data_wr;
    logic launch;
    logic capture;
    logic timeout_hit;
    logic out_fire;
    logic drain_done;
    logic retire;

    // State decode and the handshake/event strobes shared by the datapath.
    always_comb begin
        in_collect  = (state_reg == COLLECT);
        in_start    = (state_reg == START);
        in_wait     = (state_reg == WAIT);
        in_drain    = (state_reg == DRAIN);
        // Key words are always welcome while collecting; data only until full.
        in_ready    = in_collect && !((in_kind == KIND_DATA) && data_full_reg);
        in_accept   = in_valid && in_ready;
        key_wr      = in_accept && (in_kind == KIND_KEY);
        data_wr     = in_accept && (in_kind == KIND_DATA);
        launch      = in_collect && data_full_reg && key_ok_reg;
        // A done that was already high on entry is stale; require a low sample first.
        capture     = in_wait && done_low_reg && core_done;
        timeout_hit = in_wait && !capture && (timer_reg == TIMER_LAST);
        out_fire    = in_drain && out_ready;
        drain_done  = out_fire && (ocnt_reg == 2'd3);
        // A block retires either by draining its cipher or by timing out.
        retire      = drain_done || timeout_hit;
    end

    aes_word_pack u_key_pack (
        .clk     (clk),
        .reset   (reset),
        .clr     (1'b0),
        .wr_en   (key_wr),
        .wr_idx  (kcnt_reg),
        .wr_word (in_word),
        .block   (core_key)
    );

    // The data bank is wiped when its block retires; the key bank persists.
    aes_word_pack u_data_pack (
        .clk     (clk),
        .reset   (reset),
        .clr     (retire),
        .wr_en   (data_wr),
        .wr_idx  (dcnt_reg),
        .wr_word (in_word),
        .block   (core_data)
    );

    // Main sequencer with registered start pulse and output-valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= COLLECT;
            core_start_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            core_start_reg <= 1'b0;
            unique case (state_reg)
                COLLECT: begin
                    if (launch) begin
                        state_reg      <= START;
                        core_start_reg <= 1'b1;
                    end
                end
                START: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        state_reg     <= DRAIN;
                        out_valid_reg <= 1'b1;
                    end else if (timeout_hit) begin
                        state_reg <= COLLECT;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_reg     <= COLLECT;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= COLLECT;
                end
            endcase
        end
    end

    // Key word counter; key_ok drops on a fresh key and rises on its 4th word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kcnt_reg   <= 2'd0;
            key_ok_reg <= 1'b0;
        end else if (key_wr) begin
            kcnt_reg <= kcnt_reg + 2'd1;
            if (kcnt_reg == 2'd0) begin
                key_ok_reg <= 1'b0;
            end
            if (kcnt_reg == 2'd3) begin
                key_ok_reg <= 1'b1;
            end
        end
    end

    // Data word counter and full flag, released when the block retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt_reg      <= 2'd0;
            data_full_reg <= 1'b0;
        end else if (retire) begin
            dcnt_reg      <= 2'd0;
            data_full_reg <= 1'b0;
        end else if (data_wr) begin
            dcnt_reg <= dcnt_reg + 2'd1;
            if (dcnt_reg == 2'd3) begin
                data_full_reg <= 1'b1;
            end
        end
    end

    // WAIT timer and the low-sample qualifier for core_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_reg    <= 8'd0;
            done_low_reg <= 1'b0;
        end else if (in_start) begin
            timer_reg    <= 8'd0;
            done_low_reg <= 1'b0;
        end else if (in_wait) begin
            timer_reg <= timer_reg + 8'd1;
            if (!core_done) begin
                done_low_reg <= 1'b1;
            end
        end
    end

    // Cipher capture and output word index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg <= '0;
            ocnt_reg   <= 2'd0;
        end else if (capture) begin
            result_reg <= core_cipher;
            ocnt_reg   <= 2'd0;
        end else if (out_fire) begin
            ocnt_reg <= ocnt_reg + 2'd1;
        end
    end

    // Sticky error flag for an abandoned block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (timeout_hit) begin
            err_reg <= 1'b1;
        end
    end

    // Output mux; word and last are forced low whenever nothing is offered.
    always_comb begin
        out_word = '0;
        out_last = 1'b0;
        if (out_valid_reg) begin
            out_word = block_word(result_reg, ocnt_reg);
            out_last = (ocnt_reg == 2'd3);
        end
    end

    assign core_start = core_start_reg;
    assign out_valid  = out_valid_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_aes_word_loader.sv
// Directed bench for aes_word_loader with a behavioural core model and an
// output scoreboard fed when each block is issued.
module tb_aes_word_loader;

    localparam int TIMEOUT  = 63;
    localparam int CORE_LAT = 11;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2   = 128'hfedcba9876543210f0e1d2c3b4a59687;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_word;
    logic         in_kind;
    logic [127:0] core_data;
    logic [127:0] core_key;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_cipher;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_word;
    logic         out_last;
    logic         err;

    int           vectors;
    int           miscompares;
    logic [32:0]  exp_q[$];
    int           bp_hold;
    int           stale_hold;
    bit           core_never;
    int           starts;
    logic [127:0] seen_key;
    logic [127:0] seen_data;

    aes_word_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .in_kind     (in_kind),
        .core_data   (core_data),
        .core_key    (core_key),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_cipher (core_cipher),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_last    (out_last),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the AES core: the FIPS-197 C.1 vector is exact, anything
    // else gets a simple reversible scramble that still depends on key and data.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
        if (k == C1_KEY && d == C1_PT) return C1_CT;
        return {d[63:0], d[127:64]} ^ k ^ 128'h5a5a5a5a_3c3c3c3c_a5a5a5a5_c3c3c3c3;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_block(input logic [127:0] ct);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({(i == 3), ct[127-32*i -: 32]});
        end
    endtask

    // Drives one word and returns at posedge+1 of the accepting edge.
    task automatic send(input logic k, input logic [31:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_kind  = k;
        in_word  = w;
        #1;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", (n < 200), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("in  kind=%0d word=%h", k, w);
    endtask

    task automatic send_block(input logic k, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) begin
            send(k, blk[127-32*i -: 32]);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, (n < 500), 1);
    endtask

    // Called right after the edge that completes key_ok/data_full.
    task automatic check_start_pulse(input string tag, input logic [127:0] k, input logic [127:0] d);
        check({tag, "_start_early"}, core_start, 0);
        @(posedge clk); #1;
        check({tag, "_start_high"}, core_start, 1);
        check({tag, "_core_key"}, core_key, k);
        check({tag, "_core_data"}, core_data, d);
        @(posedge clk); #1;
        check({tag, "_start_single"}, core_start, 0);
    endtask

    // Core model: drops done when started (optionally late), raises it later.
    initial begin
        core_done   = 1'b0;
        core_cipher = '0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                starts++;
                seen_key  = core_key;
                seen_data = core_data;
                if (core_never) begin
                    core_done = 1'b0;
                end else begin
                    for (int i = 0; i < stale_hold; i++) @(negedge clk);
                    core_done = 1'b0;
                    for (int i = 0; i < CORE_LAT - 1; i++) @(negedge clk);
                    core_cipher = core_fn(seen_key, seen_data);
                    core_done   = 1'b1;
                end
            end
        end
    end

    // Output side: applies backpressure, checks hold stability, scores words.
    initial begin
        int          cnt;
        bit          held_v;
        logic [32:0] held;
        logic [32:0] cur;
        logic [32:0] exp;
        cnt       = 0;
        held_v    = 1'b0;
        held      = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            cur = {out_last, out_word};
            if (out_valid === 1'b1) begin
                if (held_v) check("out_hold_stable", cur, held);
                if (cnt < bp_hold) begin
                    out_ready = 1'b0;
                    cnt++;
                    held_v = 1'b1;
                    held   = cur;
                end else begin
                    out_ready = 1'b1;
                    cnt       = 0;
                    held_v    = 1'b0;
                    vectors++;
                    assert (exp_q.size() != 0) else begin
                        miscompares++;
                        $error("FAIL unexpected_out observed=%h expected=none", cur);
                    end
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        check("out_word_last", cur, exp);
                        $display("out last=%0d word=%h", cur[32], cur[31:0]);
                    end
                end
            end else begin
                out_ready = 1'b0;
                held_v    = 1'b0;
                cnt       = 0;
            end
        end
    end

    initial begin
        int n;
        int starts0;
        vectors     = 0;
        miscompares = 0;
        bp_hold     = 0;
        stale_hold  = 0;
        core_never  = 1'b0;
        starts      = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_kind     = 1'b0;
        in_word     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_core_start", core_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_word", out_word, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err, 0);
        check("rst_core_key", core_key, 0);
        check("rst_core_data", core_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // FIPS-197 C.1
        push_block(C1_CT);
        send_block(1'b1, C1_KEY);
        send_block(1'b0, C1_PT);
        check_start_pulse("c1", C1_KEY, C1_PT);
        wait_drain("c1_drain");
        check("c1_in_ready_back", in_ready, 1);
        check("c1_err", err, 0);

        // Key reuse: data only
        push_block(core_fn(C1_KEY, 128'h0));
        send_block(1'b0, 128'h0);
        wait_drain("reuse_drain");
        check("reuse_core_key", seen_key, C1_KEY);

        // Stale done held high into WAIT, plus output backpressure
        stale_hold = 5;
        bp_hold    = 3;
        push_block(core_fn(C1_KEY, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0));
        send_block(1'b0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        wait_drain("stale_drain");
        stale_hold = 0;
        bp_hold    = 0;

        // Timeout: core never finishes
        core_never = 1'b1;
        send_block(1'b0, 128'h11111111222222223333333344444444);
        n = 0;
        while (core_start !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("to_start_seen", (n < 20), 1);
        n = 0;
        while (err !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("to_wait_cycles", n, TIMEOUT + 1);
        check("to_in_ready", in_ready, 1);
        check("to_out_valid", out_valid, 0);
        core_never = 1'b0;
        push_block(core_fn(C1_KEY, 128'hdeadbeef_cafef00d_01234567_89abcdef));
        send_block(1'b0, 128'hdeadbeef_cafef00d_01234567_89abcdef);
        wait_drain("post_to_drain");
        check("post_to_err_sticky", err, 1);

        // Reset in the middle of DRAIN
        bp_hold = 1000;
        send_block(1'b0, 128'h55555555666666667777777788888888);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_drain_reached", (n < 100), 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_word", out_word, 0);
        check("arst_out_last", out_last, 0);
        check("arst_err", err, 0);
        check("arst_core_key", core_key, 0);
        check("arst_core_data", core_data, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset   = 1'b0;
        bp_hold = 0;
        exp_q.delete();
        check("arst_release_in_ready", in_ready, 1);

        // Data first with no key: must not launch; extra data refused
        starts0 = starts;
        send_block(1'b0, 128'h9abcdef0_13579bdf_2468ace0_0badf00d);
        in_valid = 1'b1;
        in_kind  = 1'b0;
        in_word  = 32'hbad0bad0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("full_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("no_key_no_start", starts, starts0);
        push_block(core_fn(KEY2, 128'h9abcdef0_13579bdf_2468ace0_0badf00d));
        send_block(1'b1, KEY2);
        check_start_pulse("late_key", KEY2, 128'h9abcdef0_13579bdf_2468ace0_0badf00d);
        wait_drain("late_key_drain");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
